// File: rtl/data_mem_bank.sv
// data_mem_bank: byte-addressed MEM-stage data memory.
// Writes place byte/half/word data into the addressed lanes. Registered reads
// extract the addressed lanes, right-justified and zero-filled.
// A debug dump engine streams every word over a valid/ready handshake.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN.
//   Defined: misaligned half/word accesses are suppressed and flagged.
//   Undefined: such accesses proceed at the aligned position.
module data_mem_bank #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_CTRL = 6,
  parameter int N_ELEMENTS  = 128,
  parameter int NB_ADDR     = $clog2(N_ELEMENTS)
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic [NB_DATA-1:0]     addr_i,
  input  logic [NB_DATA-1:0]     data_write_i,
  input  logic [NB_MEM_CTRL-1:0] MEM_control_i,
  output logic [NB_DATA-1:0]     data_read_o,
  output logic                   misalign_o,
  input  logic                   dbg_start_i,
  input  logic                   dbg_ready_i,
  output logic                   dbg_valid_o,
  output logic [NB_DATA-1:0]     dbg_data_o,
  output logic [NB_ADDR-1:0]     dbg_addr_o,
  output logic                   dbg_busy_o,
  output logic                   dbg_done_o
);

  localparam int N_LANES = NB_DATA / 8;
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_WORD = 3'b100;
  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_ELEMENTS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SEND, ST_DONE} dump_state_e;

  // Word storage; contents are deliberately not reset.
  logic [NB_DATA-1:0] mem [N_ELEMENTS];

  dump_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] index_q, index_d;
  logic               busy;
  logic               dump_valid;

  logic               cpu_rd, cpu_wr;
  logic [2:0]         size;
  logic [1:0]         offset;
  logic [NB_ADDR-1:0] word_idx;
  logic               size_ok, misaligned, access_ok;
  logic               wr_en, cpu_rd_en, mem_rd_en;
  logic [N_LANES-1:0] byte_en;
  logic [NB_DATA-1:0] wr_lanes;
  logic [NB_ADDR-1:0] rd_idx;

  logic [NB_DATA-1:0] mem_rd_q;
  logic               rd_valid_q;
  logic [2:0]         rd_size_q;
  logic [1:0]         rd_off_q;
  logic               misalign_q;
  logic [NB_DATA-1:0] load_data;
  logic [NB_DATA-1:0] byte_shifted, half_shifted;

  // Address bits above the word index and the signed flag are not used here.
  logic unused_bits;
  assign unused_bits = ^{addr_i[NB_DATA-1:NB_ADDR+2], MEM_control_i[0]};

  assign cpu_rd   = MEM_control_i[5];
  assign cpu_wr   = MEM_control_i[4];
  assign size     = MEM_control_i[3:1];
  assign offset   = addr_i[1:0];
  assign word_idx = addr_i[NB_ADDR+1:2];
  assign size_ok  = (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = ((size == SZ_HALF) && offset[0]) ||
                      ((size == SZ_WORD) && (offset != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // The dump engine owns the memory while it runs; CPU accesses are dropped.
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_SEND);
  assign access_ok  = !busy && size_ok && !misaligned;
  assign wr_en      = cpu_wr && access_ok;
  // A combined read+write performs only the write and returns zero.
  assign cpu_rd_en  = cpu_rd && !cpu_wr && access_ok;
  assign mem_rd_en  = cpu_rd_en || (state_q == ST_FETCH);
  assign rd_idx     = busy ? index_q : word_idx;

  // Lane enables: half ignores offset[0] and word ignores the offset, which is
  // the aligned placement when misalignment checking is off.
  always_comb begin
    byte_en = '0;
    case (size)
      SZ_BYTE: byte_en = N_LANES'(1) << offset;
      SZ_HALF: byte_en = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = '1;
      default: byte_en = '0;
    endcase
  end

  // Replicate right-justified store data so every lane sees its candidate byte.
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_wr_lane
    assign wr_lanes[gi*8 +: 8] = (size == SZ_BYTE) ? data_write_i[7:0] :
                                 (size == SZ_HALF) ? data_write_i[(gi % 2)*8 +: 8] :
                                                     data_write_i[gi*8 +: 8];
  end

  // Byte-enabled write and registered read port of the storage array.
  always_ff @(posedge clock_i) begin
    for (int b = 0; b < N_LANES; b++) begin
      if (wr_en && byte_en[b]) begin
        mem[word_idx][b*8 +: 8] <= wr_lanes[b*8 +: 8];
      end
    end
    if (mem_rd_en) begin
      mem_rd_q <= mem[rd_idx];
    end
  end

  // Load bookkeeping registers that travel alongside the read data.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_valid_q <= 1'b0;
      rd_size_q  <= 3'b000;
      rd_off_q   <= 2'b00;
      misalign_q <= 1'b0;
    end else begin
      rd_valid_q <= cpu_rd_en;
      if (cpu_rd_en) begin
        rd_size_q <= size;
        rd_off_q  <= offset;
      end
      misalign_q <= !busy && (cpu_rd || cpu_wr) && misaligned;
    end
  end

  // Lane extraction of the registered word, zero-filled above the access size.
  always_comb begin
    byte_shifted = mem_rd_q >> {rd_off_q, 3'b000};
    half_shifted = mem_rd_q >> {rd_off_q[1], 4'b0000};
    load_data    = '0;
    if (rd_valid_q) begin
      case (rd_size_q)
        SZ_BYTE: load_data = {{(NB_DATA-8){1'b0}}, byte_shifted[7:0]};
        SZ_HALF: load_data = {{(NB_DATA-16){1'b0}}, half_shifted[15:0]};
        SZ_WORD: load_data = mem_rd_q;
        default: load_data = '0;
      endcase
    end
  end

  assign data_read_o = load_data;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_o  = misalign_q;
`else
  assign misalign_o  = 1'b0;
`endif

  // Dump engine state register; asynchronous reset drops valid at once.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Dump engine next-state: fetch one word, present it until accepted, repeat.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    dump_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dbg_start_i) begin
          state_d = ST_FETCH;
          index_d = '0;
        end
      end
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        dump_valid = 1'b1;
        if (dbg_ready_i) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + NB_ADDR'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_valid_o = dump_valid;
  assign dbg_data_o  = dump_valid ? mem_rd_q : '0;
  assign dbg_addr_o  = dump_valid ? index_q : '0;
  assign dbg_busy_o  = busy;
  assign dbg_done_o  = (state_q == ST_DONE);

endmodule
